// File: rtl/bus_scheduler.sv
// rtl/bus_scheduler.sv - round-robin owner scheduler for the shared op/data bus with hold timeout and turnaround
module bus_scheduler #(
    parameter int ID_W     = 2,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic                 bus_clk,
    input  logic                 reset,
    input  logic [2**ID_W-1:0]   req,
    input  logic [2**ID_W-1:0]   done,
    output logic [2**ID_W-1:0]   grant,
    output logic [ID_W-1:0]      owner,
    output logic                 bus_busy,
    output logic                 timeout
);
    localparam int N_REQ = 2**ID_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [CNT_W-1:0]  hold_cnt;

    logic [ID_W-1:0]   cand;
    logic [ID_W-1:0]   arb_winner;
    logic              arb_found;
    logic              hold_hit;
    logic              owner_done;
    logic              owner_req;
    logic              release_bus;

    // Rotating search from ptr; the ID_W-bit add wraps N_REQ-1 back to 0.
    always_comb begin
        arb_found  = 1'b0;
        arb_winner = ptr;
        cand       = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr + ID_W'(i);
            if (!arb_found && req[cand]) begin
                arb_found  = 1'b1;
                arb_winner = cand;
            end
        end
    end

    assign hold_hit    = (hold_cnt == CNT_W'(MAX_HOLD - 1));
    assign owner_done  = done[owner];
    assign owner_req   = req[owner];
    assign release_bus = owner_done || !owner_req || hold_hit;

    always_ff @(posedge bus_clk) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            owner    <= '0;
            bus_busy <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, TURN: begin
                    if (arb_found) begin
                        grant    <= N_REQ'(1) << arb_winner;
                        owner    <= arb_winner;
                        bus_busy <= 1'b1;
                        hold_cnt <= '0;
                        ptr      <= arb_winner + ID_W'(1);
                        state    <= OWN;
                    end else begin
                        state    <= IDLE;
                    end
                end
                OWN: begin
                    if (release_bus) begin
                        grant    <= '0;
                        bus_busy <= 1'b0;
                        hold_cnt <= '0;
                        state    <= TURN;
                        // Forced release only; a voluntary done at the limit is a normal release.
                        timeout  <= hold_hit && owner_req && !owner_done;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_grant_onehot: assert property (@(posedge bus_clk) disable iff (!reset)
        $onehot0(grant));
    a_busy_matches: assert property (@(posedge bus_clk) disable iff (!reset)
        bus_busy == |grant);
    a_no_overlap: assert property (@(posedge bus_clk) disable iff (!reset)
        (|grant && |$past(grant)) |-> (grant == $past(grant)));

endmodule

// File: tb/tb_bus_scheduler.sv
// tb/tb_bus_scheduler.sv - directed and random checks of bus_scheduler against an ownership model
module tb_bus_scheduler;
    localparam int ID_W     = 2;
    localparam int N        = 4;
    localparam int MAX_HOLD = 16;
    localparam int CNT_W    = 5;

    logic          bus_clk = 1'b0;
    logic          reset   = 1'b0;
    logic [N-1:0]  req     = '0;
    logic [N-1:0]  done    = '0;
    logic [N-1:0]  grant;
    logic [ID_W-1:0] owner;
    logic          bus_busy;
    logic          timeout;

    int vectors     = 0;
    int miscompares = 0;

    // Model: who owns the bus, for how many grant cycles so far, and who won last.
    bit m_has;
    int m_own;
    int m_age;
    int m_last;
    bit m_to;

    bus_scheduler #(.ID_W(ID_W), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .bus_clk (bus_clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .owner   (owner),
        .bus_busy(bus_busy),
        .timeout (timeout)
    );

    always #5 bus_clk = ~bus_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        m_to = 1'b0;
        if (!reset) begin
            m_has  = 1'b0;
            m_own  = 0;
            m_age  = 0;
            m_last = N - 1;
        end else if (m_has) begin
            if (done[m_own] || !req[m_own] || m_age == MAX_HOLD) begin
                m_to  = (m_age == MAX_HOLD) && req[m_own] && !done[m_own];
                m_has = 1'b0;
            end else begin
                m_age++;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (!m_has && req[(m_last + k) % N]) begin
                    m_has  = 1'b1;
                    m_own  = (m_last + k) % N;
                    m_last = m_own;
                    m_age  = 1;
                end
            end
        end
    endtask

    task automatic cycle();
        logic [N-1:0] eg;
        @(posedge bus_clk);
        model_edge();
        #1;
        eg = m_has ? (N'(1) << m_own) : '0;
        check("grant", 32'(grant), 32'(eg));
        check("owner", 32'(owner), 32'(m_own));
        check("bus_busy", 32'(bus_busy), 32'(m_has));
        check("timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        done  = '0;
        cycle();
        reset = 1'b1;
    endtask

    initial begin
        logic [N-1:0] rot_seq [13];
        int  gcnt;
        bit  saw_to;

        rot_seq = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                    4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};

        // Reset held with all requesters active.
        reset = 1'b0;
        req   = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rst_grant", 32'(grant), 32'h0);
            check("rst_outputs", {29'b0, owner, bus_busy}, 32'h0);
            check("rst_timeout", 32'(timeout), 32'h0);
        end
        reset = 1'b1;
        cycle();
        check("first_grant", 32'(grant), 32'h1);

        // Single owner releasing with done on its third grant cycle.
        do_reset();
        req = 4'b0001;
        cycle();
        cycle();
        cycle();
        check("single_3rd", 32'(grant), 32'h1);
        done = 4'b0001;
        cycle();
        done = '0;
        check("single_turn", 32'(grant), 32'h0);
        cycle();
        check("single_regrant", 32'(grant), 32'h1);

        // Full rotation, each owner signals done on its second grant cycle.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 13; i++) begin
            cycle();
            check("rotation", 32'(grant), 32'(rot_seq[i]));
            done = (m_has && m_age == 2) ? (N'(1) << m_own) : '0;
        end
        done = '0;

        // Hold timeout with a sole requester.
        do_reset();
        req    = 4'b0100;
        gcnt   = 0;
        saw_to = 1'b0;
        for (int i = 0; i < 40 && !saw_to; i++) begin
            cycle();
            if (grant == 4'b0100) gcnt++;
            if (timeout) saw_to = 1'b1;
        end
        check("to_pulse_seen", 32'(saw_to), 32'h1);
        check("to_hold_len", 32'(gcnt), 32'(MAX_HOLD));
        cycle();
        check("to_regrant", 32'(grant), 32'h4);
        check("to_one_cycle", 32'(timeout), 32'h0);
        for (int i = 0; i < 40 && m_age < MAX_HOLD; i++) cycle();
        done = 4'b0100;
        cycle();
        done = '0;
        check("done_at_limit_no_to", 32'(timeout), 32'h0);
        check("done_at_limit_rel", 32'(grant), 32'h0);

        // Wrap from owner 3 to owner 0 after owner 3 drops its request.
        do_reset();
        req = 4'b1000;
        cycle();
        req = 4'b1001;
        cycle();
        check("wrap_hold3", 32'(grant), 32'h8);
        req = 4'b0001;
        cycle();
        check("drop_release", 32'(grant), 32'h0);
        cycle();
        check("wrap_grant0", 32'(grant), 32'h1);

        // Reset in the middle of an ownership.
        do_reset();
        req = 4'b0010;
        for (int i = 0; i < 6; i++) cycle();
        check("mid_owner", 32'(grant), 32'h2);
        reset = 1'b0;
        cycle();
        check("mid_rst_grant", 32'(grant), 32'h0);
        reset = 1'b1;
        req   = 4'b0011;
        cycle();
        check("mid_ptr0", 32'(grant), 32'h1);

        // Random traffic, two mixes: busy done traffic, then long holds.
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 1500; i++) begin
                for (int b = 0; b < N; b++) begin
                    if ($urandom_range(ph == 0 ? 7 : 31) == 0) req[b] = ~req[b];
                    done[b] = ($urandom_range(ph == 0 ? 5 : 60) == 0);
                end
                reset = ($urandom_range(299) != 0);
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_scheduler.md
Name: bus_scheduler

Overview:
- Owns the shared op/data bus between the accumulator processors and accumulator memory; replaces the bare round-robin arbiter.
- Round-robin grant with ownership hold, owner-signalled release and hold timeout.
- Inserts one mandatory turnaround cycle between owners so tri-stated data drivers never overlap.
- Runs on the bus clock.

Parameters:
- ID_W, 2, width of the owner index. The number of requesters is N_REQ = 2**ID_W (4 by default).
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold grant. Legal range 2..2**CNT_W.
- CNT_W, 5, width of the hold counter.

Ports:
- bus_clk  in  1  bus clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset: reset==0 at the bus_clk rising edge resets the block.
- req  in  N_REQ  per-requester bus request, level; held high while the bus is wanted.
- done  in  N_REQ  per-requester last-cycle flag; only the bit of the current owner is honoured.
- grant  out  N_REQ  one-hot registered grant; 0 when no owner.
- owner  out  ID_W  index of the current or most recent owner.
- bus_busy  out  1  registered, equals |grant.
- timeout  out  1  single-cycle pulse when an owner is forcibly released.

Behaviour:
- Reset (reset==0 at edge):
  - state=IDLE, ptr=0, hold_cnt=0.
  - grant=0, owner=0, bus_busy=0, timeout=0.
  - Reset overrides everything, including mid-ownership.
- Arbitration function (used in IDLE and TURN):
  - Search req starting at index ptr, ascending, wrapping N_REQ-1 -> 0.
  - The first set bit wins.
- IDLE:
  - If any req bit is set at edge k, then after edge k: grant=onehot(winner), owner=winner, bus_busy=1, hold_cnt=0, ptr=(winner+1) mod N_REQ, state=OWN.
  - Latency is one edge from sampled req to visible grant.
  - If no req is set, stay in IDLE with outputs unchanged (grant=0).
- OWN, evaluated each edge:
  - Release if done[owner]==1, OR req[owner]==0, OR hold_cnt==MAX_HOLD-1.
  - On release: grant=0, bus_busy=0, hold_cnt=0, state=TURN.
  - timeout=1 for that one cycle only when the release was caused solely by hold_cnt (done and req still high).
  - If done coincides with the hold limit, treat it as a normal release with no timeout pulse.
  - No release: hold_cnt+=1; grant holds.
  - Grant is therefore high for at most MAX_HOLD cycles.
  - req and done bits of non-owners are ignored while in OWN.
- TURN:
  - Lasts exactly one cycle, with grant=0 throughout.
  - At the closing edge, run the arbitration function:
    - Winner present: go to OWN exactly as from IDLE.
    - No winner: go to IDLE.
  - The dead gap between consecutive owners is therefore exactly 1 cycle.
- Fairness:
  - ptr advances past each winner at grant time.
  - A timed-out or released requester that still requests goes behind all other active requesters.
  - A sole requester is re-granted after the 1-cycle TURN.
- owner retains its last value while in IDLE/TURN.
- timeout is 0 in every cycle except the release pulse.
- Invariants, checked by assertion:
  - grant is one-hot or zero.
  - bus_busy==|grant.
  - grant is never high in consecutive cycles for different requesters.

Test Plan:
- Reset: hold reset=0 for 3 edges with req=4'b1111, done=0 -> grant=0, owner=0, bus_busy=0, timeout=0. First edge with reset=1 -> grant=4'b0001.
- Single owner: req=4'b0001 held, done[0] pulsed on the 3rd grant cycle -> grant=0001 for exactly 3 cycles, then 0 for 1 TURN cycle, then 0001 again (req still high).
- Full rotation: req=4'b1111 held, each owner pulses done on its 2nd grant cycle -> grant sequence 0001,0001,0,0010,0010,0,0100,0100,0,1000,1000,0,0001; owner 0,1,2,3,0.
- Timeout: MAX_HOLD=16, req=4'b0100 held, done=0 -> grant=0100 for exactly 16 cycles; timeout=1 in the cycle after the last grant cycle; re-grant 0100 after the 1 TURN cycle. Same run with done[2]=1 on cycle 16 -> no timeout pulse.
- Wrap and early drop: owner 3 drops req[3] while req=4'b1001 -> release, TURN, then grant=0001 (wrap). Owner dropping req mid-hold releases on that edge.
- Reset mid-ownership: reset=0 for 1 edge while grant=0010 with hold_cnt=5 -> grant=0, ptr=0. Then req=4'b0011 -> grant=0001 first.
